mem_ctrl: RTL and testbench

Load/store initiator sitting between the core's execute stage and the byte-addressed `Mem` block. It accepts one RV32I load or store request at a time. It drives `Mem`'s op/rw/addr/data_w port and captures data_r. Loads are size-selected and sign/zero-extended. Sub-word stores are performed as read-modify-write, because the memory always writes four bytes starting at addr.

---
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Load/store initiator between the execute stage and the byte-addressed Mem block.
// Optional macro MEM_CTRL_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  mem_op_q, mem_op_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  illegal;
    logic                  misalign;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] rmw_word;

    assign illegal = req_we ? (req_funct3 > 3'd2)
                            : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    // Legal funct3 low bits encode size: 0=byte, 1=half, 2=word.
    assign misalign = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        load_ext = mem_data_r;
        case (f3_q)
            3'd0:    load_ext = {{(DATA_WIDTH-8){mem_data_r[7]}}, mem_data_r[7:0]};
            3'd1:    load_ext = {{(DATA_WIDTH-16){mem_data_r[15]}}, mem_data_r[15:0]};
            3'd4:    load_ext = {{(DATA_WIDTH-8){1'b0}}, mem_data_r[7:0]};
            3'd5:    load_ext = {{(DATA_WIDTH-16){1'b0}}, mem_data_r[15:0]};
            default: load_ext = mem_data_r;
        endcase
    end

    // Mem always writes four bytes, so sub-word stores merge into the word just read.
    assign rmw_word = f3_q[0] ? {mem_data_r[DATA_WIDTH-1:16], wdata_q[15:0]}
                              : {mem_data_r[DATA_WIDTH-1:8], wdata_q[7:0]};

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        mem_op_d     = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_data_w_d = mem_data_w_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata[15:0];
                    if (illegal || misalign) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we || req_funct3 != 3'd2) begin
                        state_d    = RD;
                        mem_op_d   = 1'b1;
                        mem_rw_d   = 1'b0;
                        mem_addr_d = req_addr;
                    end else begin
                        state_d      = WR;
                        mem_op_d     = 1'b1;
                        mem_rw_d     = 1'b1;
                        mem_addr_d   = req_addr;
                        mem_data_w_d = req_wdata;
                    end
                end
            end
            RD: begin
                if (!we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext;
                end else begin
                    state_d      = WR;
                    mem_op_d     = 1'b1;
                    mem_rw_d     = 1'b1;
                    mem_data_w_d = rmw_word;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            wdata_q      <= '0;
            mem_op_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_w_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            mem_op_q     <= mem_op_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_w_q <= mem_data_w_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !sys_rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_op     = mem_op_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_w = mem_data_w_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-array Mem stand-in plus a byte-level reference model.
module tb_mem_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_op, mem_rw;
    logic [31:0] mem_addr, mem_data_w;
    logic [31:0] mem_data_r = 32'd0;

    logic [7:0]  dmem [256];
    logic [7:0]  rmem [256];
    int          total = 0;
    int          bad   = 0;

    mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_op(mem_op), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    always #5 sys_clk = ~sys_clk;

    // Byte-addressed Mem: acts on negedge while op is high.
    always @(negedge sys_clk) begin
        if (mem_op) begin
            if (mem_rw) begin
                for (int i = 0; i < 4; i++) dmem[8'(mem_addr[7:0] + i)] = mem_data_w[8*i +: 8];
            end else begin
                for (int i = 0; i < 4; i++) mem_data_r[8*i +: 8] = dmem[8'(mem_addr[7:0] + i)];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rword(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rmem[8'(a[7:0] + i)];
        return w;
    endfunction

    // Architectural effect of one request: result, error, latency and memory-access count.
    function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                      output int lat, output int nops);
        int  size;
        bit  legal, mis;
        logic [31:0] val;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        mis   = 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        mis   = (addr % size) != 0;
`endif
        if (!legal || mis) begin
            err = 1'b1; rd = 32'd0; lat = 0; nops = 0;
        end else if (!we) begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val |= 32'(rmem[8'(addr[7:0] + i)]) << (8*i);
            if (f3 < 3'd4 && size < 4 && val[8*size-1]) val |= 32'hFFFF_FFFF << (8*size);
            err = 1'b0; rd = val; lat = 1; nops = 1;
        end else begin
            for (int i = 0; i < size; i++) rmem[8'(addr[7:0] + i)] = 8'(wd >> (8*i));
            err = 1'b0; rd = 32'd0;
            lat = (size == 4) ? 1 : 2;
            nops = lat;
        end
    endfunction

    // Called at 1ns after a posedge; returns there, one cycle after the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        e_err;
        logic [31:0] e_rd, e_w;
        int          e_lat, e_nops, lat, nops, guard;
        bit          seen;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge sys_clk); #1; guard++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        ref_model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nops);
        e_w = rword(addr);
        @(posedge sys_clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
        chk("busy_ready", 32'(req_ready), 32'd0);
        lat = 0; nops = 0; seen = 0; got = 32'd0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (mem_op) begin
                nops++;
                chk("mem_addr", mem_addr, addr);
                chk("mem_rw", 32'(mem_rw), 32'(we && (nops == 2 || f3 == 3'd2)));
                if (mem_rw) chk("mem_data_w", mem_data_w, e_w);
            end
            if (rsp_valid) begin
                seen = 1; lat = c; got = rsp_rdata;
            end else begin
                @(posedge sys_clk); #1;
            end
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(e_lat));
        chk("mem_op_cycles", 32'(nops), 32'(e_nops));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rd);
        @(posedge sys_clk); #1;
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("rdata_hold", rsp_rdata, e_rd);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, exp;
        int          seen, diffs;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'd0;
            rmem[i] = 8'd0;
        end
        sys_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_op", 32'(mem_op), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_dataw", mem_data_w, 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Directed sequence on bytes 0x20..0x23 = 1A,9B,1C,FD.
        do_req(1'b1, 3'd2, 32'h20, 32'hFD1C_9B1A, got);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, got); chk("lw20", got, 32'hFD1C_9B1A);
        do_req(1'b0, 3'd0, 32'h21, 32'h0, got); chk("lb21", got, 32'hFFFF_FF9B);
        do_req(1'b0, 3'd4, 32'h21, 32'h0, got); chk("lbu21", got, 32'h0000_009B);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, got); chk("lh22", got, 32'hFFFF_FD1C);
        do_req(1'b0, 3'd5, 32'h22, 32'h0, got); chk("lhu22", got, 32'h0000_FD1C);
        do_req(1'b1, 3'd0, 32'h20, 32'h1234_5677, got);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, got); chk("lw20_after_sb", got, 32'hFD1C_9B77);
        do_req(1'b0, 3'd1, 32'h21, 32'h0, got);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        exp = 32'h0;
`else
        exp = 32'h0000_1C9B;
`endif
        chk("lh21", got, exp);
        do_req(1'b0, 3'd3, 32'h20, 32'h0, got); chk("ld_f3_3", got, 32'h0);

        // SH aborted by reset on the edge that would start its write.
        do_req(1'b1, 3'd2, 32'h20, 32'hFD1C_9B1A, got);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'h0000_BEEF;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        chk("abort_rd_op", 32'(mem_op), 32'd1);
        chk("abort_rd_rw", 32'(mem_rw), 32'd0);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk("abort_op", 32'(mem_op), 32'd0);
        chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        sys_rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid || mem_op) seen++;
            @(posedge sys_clk); #1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, got); chk("lw20_after_abort", got, 32'hFD1C_9B1A);

        // Random mix of legal, illegal and misaligned requests in a small window.
        for (int n = 0; n < 120; n++) begin
            logic        we;
            logic [2:0]  f3;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 1) == 1 && f3 < 3'd2) f3 = f3 + 3'd4;
            do_req(we, f3, 32'($urandom_range(32'h20, 32'h3F)), $urandom, got);
            repeat ($urandom_range(0, 2)) begin
                @(posedge sys_clk); #1;
            end
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
